// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic stage register between adjacent MIPS pipeline stages.
// Carries an opaque payload plus PC+8, branch-delay flag, exception code and
// Tnew. Supports bubble insertion (clr) and exception flush (req).
//
// Build option: define PIPE_SKID_EN to add a second (skid) entry so that
// in_ready is a registered signal. Without it there is a single head entry
// and in_ready is combinational from out_ready.
//
// Handshake: an entry moves across an interface on a rising edge where both
// valid and ready are high (push on the input side, pop on the output side);
// valid is never conditioned on ready, and an offered entry is expected to be
// held stable by the source until it is accepted.
module pipe_stage_buf #(
  parameter int          DATA_W     = 64,
  parameter int          TNEW_W     = 3,
  parameter int          TNEW_DEC   = 1,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc8,
  input  logic              in_bd,
  input  logic [4:0]        in_exc,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc8,
  output logic              out_bd,
  output logic [4:0]        out_exc,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [31:0]       RESET_PC8   = RESET_PC + 32'd8;
  localparam logic [31:0]       HANDLER_PC8 = HANDLER_PC + 32'd8;
  localparam logic [TNEW_W-1:0] TNEW_DEC_W  = TNEW_W'(TNEW_DEC);

  // Head entry
  logic              main_v_q, main_v_d;
  logic [31:0]       pc8_q,    pc8_d;
  logic              bd_q,     bd_d;
  logic [4:0]        exc_q,    exc_d;
  logic [TNEW_W-1:0] tnew_q,   tnew_d;
  logic [DATA_W-1:0] data_q,   data_d;

  logic              push;
  logic              pop;

  // Fields actually written for an accepted entry (bubbled when clr is high)
  logic [4:0]        wr_exc;
  logic [TNEW_W-1:0] wr_tnew;
  logic [DATA_W-1:0] wr_data;

  // A bubble keeps pc8/bd so EPC tracking stays correct through it
  always_comb begin
    wr_exc  = clr ? '0 : in_exc;
    wr_tnew = clr ? '0 : in_tnew;
    wr_data = clr ? '0 : in_data;
  end

  assign pop = main_v_q && out_ready;

`ifdef PIPE_SKID_EN
  // Skid entry: only ever filled while the head is occupied and not popping
  logic              skid_v_q,    skid_v_d;
  logic [31:0]       skid_pc8_q,  skid_pc8_d;
  logic              skid_bd_q,   skid_bd_d;
  logic [4:0]        skid_exc_q,  skid_exc_d;
  logic [TNEW_W-1:0] skid_tnew_q, skid_tnew_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  assign in_ready = !skid_v_q;
  assign push     = in_valid && in_ready;

  // Next-state for head and skid; flush beats everything, then FIFO moves
  always_comb begin
    main_v_d    = main_v_q;
    pc8_d       = pc8_q;
    bd_d        = bd_q;
    exc_d       = exc_q;
    tnew_d      = tnew_q;
    data_d      = data_q;
    skid_v_d    = skid_v_q;
    skid_pc8_d  = skid_pc8_q;
    skid_bd_d   = skid_bd_q;
    skid_exc_d  = skid_exc_q;
    skid_tnew_d = skid_tnew_q;
    skid_data_d = skid_data_q;
    if (req) begin
      main_v_d    = 1'b0;
      pc8_d       = HANDLER_PC8;
      bd_d        = 1'b0;
      exc_d       = '0;
      tnew_d      = '0;
      data_d      = '0;
      skid_v_d    = 1'b0;
      skid_pc8_d  = '0;
      skid_bd_d   = 1'b0;
      skid_exc_d  = '0;
      skid_tnew_d = '0;
      skid_data_d = '0;
    end else if (pop && skid_v_q) begin
      // in_ready is low here, so no push can collide with the skid move
      main_v_d = 1'b1;
      pc8_d    = skid_pc8_q;
      bd_d     = skid_bd_q;
      exc_d    = skid_exc_q;
      tnew_d   = skid_tnew_q;
      data_d   = skid_data_q;
      skid_v_d = 1'b0;
    end else if (push && (!main_v_q || pop)) begin
      main_v_d = 1'b1;
      pc8_d    = in_pc8;
      bd_d     = in_bd;
      exc_d    = wr_exc;
      tnew_d   = wr_tnew;
      data_d   = wr_data;
    end else if (push) begin
      skid_v_d    = 1'b1;
      skid_pc8_d  = in_pc8;
      skid_bd_d   = in_bd;
      skid_exc_d  = wr_exc;
      skid_tnew_d = wr_tnew;
      skid_data_d = wr_data;
    end else if (pop) begin
      // Fields hold so out_pc8/out_bd still describe the last instruction
      main_v_d = 1'b0;
    end
  end

  // Skid entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_v_q    <= 1'b0;
      skid_pc8_q  <= '0;
      skid_bd_q   <= 1'b0;
      skid_exc_q  <= '0;
      skid_tnew_q <= '0;
      skid_data_q <= '0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_pc8_q  <= skid_pc8_d;
      skid_bd_q   <= skid_bd_d;
      skid_exc_q  <= skid_exc_d;
      skid_tnew_q <= skid_tnew_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign in_ready = !main_v_q || out_ready;
  assign push     = in_valid && in_ready;

  // Next-state for the single head entry; flush beats load beats drain
  always_comb begin
    main_v_d = main_v_q;
    pc8_d    = pc8_q;
    bd_d     = bd_q;
    exc_d    = exc_q;
    tnew_d   = tnew_q;
    data_d   = data_q;
    if (req) begin
      main_v_d = 1'b0;
      pc8_d    = HANDLER_PC8;
      bd_d     = 1'b0;
      exc_d    = '0;
      tnew_d   = '0;
      data_d   = '0;
    end else if (push) begin
      main_v_d = 1'b1;
      pc8_d    = in_pc8;
      bd_d     = in_bd;
      exc_d    = wr_exc;
      tnew_d   = wr_tnew;
      data_d   = wr_data;
    end else if (pop) begin
      // Fields hold so out_pc8/out_bd still describe the last instruction
      main_v_d = 1'b0;
    end
  end
`endif

  // Head entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q <= 1'b0;
      pc8_q    <= RESET_PC8;
      bd_q     <= 1'b0;
      exc_q    <= '0;
      tnew_q   <= '0;
      data_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      pc8_q    <= pc8_d;
      bd_q     <= bd_d;
      exc_q    <= exc_d;
      tnew_q   <= tnew_d;
      data_q   <= data_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_pc8   = pc8_q;
  assign out_bd    = bd_q;
  assign out_exc   = exc_q;
  assign out_data  = data_q;

  // Tnew counts down one stage further; saturate so it never wraps
  assign out_tnew = (tnew_q > TNEW_DEC_W) ? (tnew_q - TNEW_DEC_W) : '0;

endmodule
